// File: rtl/i2s_decoder_if.sv
// i2s_decoder_if: I2S pin bundle plus the recovered stereo sample outputs.
interface i2s_decoder_if #(
    parameter int DATA_W = 16
);
    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic [DATA_W-1:0] data_l;
    logic [DATA_W-1:0] data_r;
    logic              valid;
    logic              locked;
    logic              short_slot;

    modport master (
        output bclk, lrclk, sdata,
        input  data_l, data_r, valid, locked, short_slot
    );

    modport slave (
        input  bclk, lrclk, sdata,
        output data_l, data_r, valid, locked, short_slot
    );
endinterface

// File: rtl/i2s_decoder.sv
// i2s_decoder: oversamples an async I2S stream in the mclk domain and emits one
// left-justified stereo pair per frame with a valid strobe and a short-slot flag.
module i2s_decoder #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 6
) (
    input  logic          i_mclk,
    input  logic          i_rst_x,
    i2s_decoder_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    localparam logic [CNT_W:0] DW = (CNT_W+1)'(DATA_W);

    state_t            state;
    logic              bclk_s1, bclk_s2, lr_s1, lr_s2, sd_s1, sd_s2;
    logic              b_prev, lr_prev, short_flag;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [DATA_W-1:0] shift, shift_app, hold_l;
    logic              bit_tick, lr_change, slot_short;

    // shift_app is the slot register with the current bit placed MSB-first
    always_comb begin
        bit_tick   = bclk_s2 & ~b_prev;
        lr_change  = lr_s2 != lr_prev;
        cnt_inc    = &cnt ? cnt : cnt + CNT_W'(1);
        slot_short = {1'b0, cnt_inc} < DW;
        shift_app  = shift;
        for (int i = 0; i < DATA_W; i++)
            if ({1'b0, cnt} == (CNT_W+1)'(DATA_W-1-i)) shift_app[i] = sd_s2;
    end

    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            {bclk_s1, bclk_s2, lr_s1, lr_s2, sd_s1, sd_s2} <= '0;
            b_prev         <= 1'b0;
            lr_prev        <= 1'b0;
            state          <= HUNT;
            cnt            <= '0;
            shift          <= '0;
            hold_l         <= '0;
            short_flag     <= 1'b0;
            bus.data_l     <= '0;
            bus.data_r     <= '0;
            bus.valid      <= 1'b0;
            bus.locked     <= 1'b0;
            bus.short_slot <= 1'b0;
        end else begin
            bclk_s1        <= bus.bclk;
            bclk_s2        <= bclk_s1;
            lr_s1          <= bus.lrclk;
            lr_s2          <= lr_s1;
            sd_s1          <= bus.sdata;
            sd_s2          <= sd_s1;
            b_prev         <= bclk_s2;
            bus.valid      <= 1'b0;
            bus.short_slot <= 1'b0;
            if (bit_tick) begin
                lr_prev <= lr_s2;
                if (state != HUNT) begin
                    cnt   <= lr_change ? '0 : cnt_inc;
                    shift <= lr_change ? '0 : shift_app;
                end
                // the tick that sees a word-select change still carries the old channel's LSB
                if (lr_change) begin
                    case (state)
                        HUNT: if (!lr_s2) begin
                            state      <= LEFT;
                            cnt        <= '0;
                            shift      <= '0;
                            short_flag <= 1'b0;
                        end
                        LEFT: if (lr_s2) begin
                            hold_l     <= shift_app;
                            short_flag <= short_flag | slot_short;
                            state      <= RIGHT;
                        end
                        RIGHT: if (!lr_s2) begin
                            bus.data_l     <= hold_l;
                            bus.data_r     <= shift_app;
                            bus.valid      <= 1'b1;
                            bus.short_slot <= short_flag | slot_short;
                            short_flag     <= 1'b0;
                            bus.locked     <= 1'b1;
                            state          <= LEFT;
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end
endmodule
